// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32-bit MULT/MULTU/DIV/DIVU into HI/LO, plus MTHI/MTLO writes.
// Sign handling is done on magnitudes: fixed up in PREP and restored in FIX.
module mul_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} stateT;

    stateT       state, nextState;
    logic        isDiv, isSigned, resNeg, remNeg, divGeq;
    logic [31:0] aReg, bReg, origA, divDiff, quot, rem;
    logic [63:0] acc, prodFix;
    logic [4:0]  cnt;
    logic [32:0] mulSum, remShift;

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = (start && !cancel && !op[2]) ? PREP : IDLE;
            PREP:    nextState = cancel ? IDLE : ITER;
            ITER:    nextState = cancel ? IDLE : (cnt == 5'd31 ? FIX : ITER);
            default: nextState = IDLE;
        endcase
    end

    assign busy     = state != IDLE;
    assign mulSum   = {1'b0, acc[63:32]} + {1'b0, bReg[0] ? aReg : 32'd0};
    assign remShift = {acc[63:32], aReg[31]};
    assign divGeq   = remShift >= {1'b0, bReg};
    // The difference always fits in 32 bits because the partial remainder stays below the divisor.
    assign divDiff  = remShift[31:0] - bReg;
    assign prodFix  = resNeg ? -acc : acc;
    assign quot     = resNeg ? -acc[31:0] : acc[31:0];
    assign rem      = remNeg ? -acc[63:32] : acc[63:32];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            isDiv    <= 1'b0;
            isSigned <= 1'b0;
            resNeg   <= 1'b0;
            remNeg   <= 1'b0;
            aReg     <= '0;
            bReg     <= '0;
            origA    <= '0;
            acc      <= '0;
            cnt      <= '0;
        end else begin
            done <= state == FIX && !cancel;
            case (state)
                IDLE: if (start && !cancel) begin
                    if (op == 3'd4) hi <= a;
                    else if (op == 3'd5) lo <= a;
                    isDiv    <= op[1];
                    isSigned <= !op[0];
                    aReg     <= a;
                    bReg     <= b;
                    origA    <= a;
                end
                PREP: begin
                    aReg   <= (isSigned && aReg[31]) ? -aReg : aReg;
                    bReg   <= (isSigned && bReg[31]) ? -bReg : bReg;
                    resNeg <= isSigned && (aReg[31] ^ bReg[31]);
                    remNeg <= isSigned && aReg[31];
                    acc    <= '0;
                    cnt    <= '0;
                end
                ITER: begin
                    cnt <= cnt + 5'd1;
                    if (isDiv) begin
                        acc  <= divGeq ? {divDiff, acc[30:0], 1'b1} : {remShift[31:0], acc[30:0], 1'b0};
                        aReg <= aReg << 1;
                    end else begin
                        acc  <= {mulSum, acc[31:1]};
                        bReg <= bReg >> 1;
                    end
                end
                default: if (!cancel) begin
                    if (!isDiv) {hi, lo} <= prodFix;
                    else if (bReg == 32'd0) begin
                        hi <= origA;
                        lo <= 32'hFFFF_FFFF;
                    end else begin
                        hi <= rem;
                        lo <= quot;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and random checks of mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;
    logic        clk = 0, reset = 0, start = 0, cancel = 0;
    logic [2:0]  op = 3'd6;
    logic [31:0] a = 0, b = 0;
    logic        busy, done;
    logic [31:0] hi, lo;
    logic [31:0] expHi = 0, expLo = 0;
    int          vectors = 0, miscompares = 0;

    mul_div_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns {hi, lo} for an arithmetic op, computed with plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, q, m;
        logic [63:0] r;
        sx = $signed(x);
        sy = $signed(y);
        r  = '0;
        if (o[1] && y == 32'd0) r = {x, 32'hFFFF_FFFF};
        else if (o == 3'd0) r = sx * sy;
        else if (o == 3'd1) r = {32'd0, x} * {32'd0, y};
        else if (o == 3'd2) begin
            q = sx / sy;
            m = sx % sy;
            r = {m[31:0], q[31:0]};
        end else r = {x % y, x / y};
        return r;
    endfunction

    // Issues an arithmetic op; optionally fires a blocked MTLO at busy cycle mtloAt or cancel at cancelAt.
    task automatic runOp(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input int mtloAt, input int cancelAt);
        int n;
        @(negedge clk);
        start = 1; op = o; a = x; b = y;
        @(negedge clk);
        start = 0; op = 3'd6; a = $urandom; b = $urandom;
        n = 1;
        while (busy && n < 100) begin
            start  = (n == mtloAt);
            op     = 3'd5;
            a      = 32'hDEAD_BEEF;
            cancel = (n == cancelAt);
            @(negedge clk);
            n++;
        end
        start = 0; cancel = 0; op = 3'd6;
        if (cancelAt == 0) {expHi, expLo} = model(o, x, y);
        check({tag, " busy cycles"}, 64'(n - 1), cancelAt != 0 ? 64'(cancelAt) : 64'd34);
        check({tag, " done"}, {63'd0, done}, cancelAt != 0 ? 64'd0 : 64'd1);
        check({tag, " hi"}, {32'd0, hi}, {32'd0, expHi});
        check({tag, " lo"}, {32'd0, lo}, {32'd0, expLo});
        @(negedge clk);
        check({tag, " done drop"}, {63'd0, done}, 64'd0);
    endtask

    task automatic moveTo(input string tag, input logic [2:0] o, input logic [31:0] x, input logic c);
        @(negedge clk);
        start = 1; op = o; a = x; cancel = c;
        @(negedge clk);
        start = 0; cancel = 0; op = 3'd6;
        if (!c && o == 3'd4) expHi = x;
        if (!c && o == 3'd5) expLo = x;
        check({tag, " busy"}, {63'd0, busy}, 64'd0);
        check({tag, " hi"}, {32'd0, hi}, {32'd0, expHi});
        check({tag, " lo"}, {32'd0, lo}, {32'd0, expLo});
    endtask

    initial begin
        logic [2:0] ro;
        logic [31:0] rb;
        #1 reset = 1;
        #3;
        check("reset state", {busy, done, hi, lo}, 66'd0);
        @(negedge clk);
        @(negedge clk) reset = 0;

        runOp("MULTU max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        check("MULTU max const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        runOp("MULT -3*5", 3'd0, 32'hFFFF_FFFD, 32'd5, 0, 0);
        check("MULT const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        runOp("DIV -7/2", 3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
        check("DIV const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        runOp("DIVU by 0", 3'd3, 32'h0000_1234, 32'd0, 0, 0);
        check("DIVU0 const", {hi, lo}, 64'h0000_1234_FFFF_FFFF);
        runOp("DIV by 0 neg", 3'd2, 32'h8000_0007, 32'd0, 0, 0);
        runOp("DIV overflow", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        check("DIV ovf const", {hi, lo}, 64'h0000_0000_8000_0000);

        moveTo("MTHI", 3'd4, 32'hCAFE_BABE, 1'b0);
        moveTo("MTLO", 3'd5, 32'h1357_9BDF, 1'b0);
        moveTo("op7 noop", 3'd7, 32'h5555_AAAA, 1'b0);
        moveTo("MTHI+cancel", 3'd4, 32'h0BAD_F00D, 1'b1);
        moveTo("MULT+cancel", 3'd0, 32'h0000_0009, 1'b1);

        runOp("MULT with MTLO", 3'd0, 32'h0001_0001, 32'hFFFF_0003, 5, 0);
        runOp("MULTU cancel", 3'd1, 32'd3, 32'd4, 0, 10);
        runOp("DIVU cancel late", 3'd3, 32'd100, 32'd7, 0, 34);
        runOp("MTHI blocked", 3'd1, 32'd11, 32'd13, 0, 0);

        for (int i = 0; i < 12; i++) begin
            ro = 3'($urandom_range(0, 3));
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : $urandom_range(1, 300));
            runOp($sformatf("rand%0d op%0d", i, ro), ro, $urandom, rb, 0, 0);
        end

        @(negedge clk);
        start = 1; op = 3'd3; a = 32'hFFFF_0000; b = 32'd3;
        @(negedge clk);
        start = 0; op = 3'd6;
        repeat (18) @(negedge clk);
        @(posedge clk);
        #2 reset = 1;
        #1;
        check("async reset", {busy, done, hi, lo}, 66'd0);
        expHi = 0; expLo = 0;
        @(negedge clk) reset = 0;
        runOp("MULTU 2*3", 3'd1, 32'd2, 32'd3, 0, 0);
        check("MULTU 2*3 const", {hi, lo}, 64'd6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit in the EX stage. It takes the already-forwarded rs/rt operand values and computes MULT, MULTU, DIV and DIVU results into the architectural HI/LO registers. It also performs MTHI/MTLO writes. While an operation is in flight it raises `busy`; the hazard unit uses `busy` to stall any MFHI/MFLO or further HI/LO-writing instruction in ID/EX.

## Interface
- Parameters: none; datapath is fixed at 32 bits.
- `clk  input  1` — sole clock; all state updates on rising edge.
- `reset  input  1` — asynchronous, active-high; clears all state.
- `start  input  1` — qualifies `op`; sampled only when `busy`=0.
- `op  input  3` — 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op.
- `a  input  32` — forwarded rs value (multiplicand / dividend / MTHI/MTLO source).
- `b  input  32` — forwarded rt value (multiplier / divisor).
- `cancel  input  1` — flush from exception/branch; aborts the in-flight op.
- `busy  output  1` — high while an arithmetic op is in progress.
- `done  output  1` — one-cycle pulse when HI/LO have just been updated by an arithmetic op.
- `hi  output  32` — HI register.
- `lo  output  32` — LO register.

## Operation
- State machine: IDLE → PREP → ITER → FIX → IDLE. `busy` = (state ≠ IDLE), decoded from registered state.
- IDLE with `start`=1 and `cancel`=0:
  - op 0–3: latch op and operands, go to PREP.
  - op 4: hi←a at the edge; stays in IDLE; no `busy`, no `done`.
  - op 5: lo←a at the edge; stays in IDLE; no `busy`, no `done`.
  - op 6/7: ignored.
- PREP (1 cycle):
  - Signed ops (0, 2): take two's-complement magnitudes of a and b. Record result sign = a[31]^b[31] and remainder sign = a[31].
  - Unsigned ops: use the operands as-is.
  - Clear the 64-bit accumulator and the 5-bit counter.
- ITER (exactly 32 cycles, counter 0..31):
  - Multiply: radix-2 shift-add, one multiplier bit per cycle.
  - Divide: restoring division, one quotient bit per cycle.
  - Leave ITER when the counter = 31.
- FIX (1 cycle):
  - Multiply: negate the 64-bit product if the result sign is set; hi←product[63:32], lo←product[31:0].
  - Divide: negate the quotient if the result sign is set and the remainder if the remainder sign is set; lo←quotient, hi←remainder.
  - Assert `done` in the following cycle.
- Divide by zero (b=0 latched at start, DIV or DIVU): full latency still applies; result is hi←a (original, unmodified), lo←32'hFFFFFFFF.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (falls out of the magnitude arithmetic; no trap).
- `start` while `busy`=1 is ignored for all ops, including MTHI/MTLO. The hazard unit must hold such instructions.
- `cancel`:
  - While busy: next state is IDLE; hi/lo unchanged; no `done`.
  - While IDLE: blocks `start` in the same cycle (cancel wins, so no MTHI/MTLO write occurs either).
- Reset: hi=0, lo=0, busy=0, done=0, state IDLE, counter 0. Reset mid-operation discards the op immediately.

## Timing
- `start` accepted in cycle T:
  - PREP in T+1.
  - ITER in T+2..T+33.
  - FIX in T+34.
  - `busy`=1 for T+1..T+34 (34 cycles).
  - New hi/lo visible and `done`=1 in T+35; `busy`=0 in T+35.
- A new `start` is accepted in T+35 (back-to-back ops have no extra bubble).
- MTHI/MTLO accepted in T: new value visible in T+1.
- `cancel` sampled in cycle C while busy: `busy`=0 in C+1.
- If `cancel` arrives in FIX, no write occurs.
- hi/lo change only at the FIX edge, at an MTHI/MTLO edge, or at reset; they are never partially updated.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF at T → `busy` high T+1..T+34; in T+35 hi=0xFFFFFFFE, lo=0x00000001, `done`=1 for exactly one cycle.
- MULT a=0xFFFFFFFD (−3), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1; then DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=0x1234, b=0 → hi=0x00001234, lo=0xFFFFFFFF after 34 busy cycles; DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI a=0xCAFEBABE while idle → hi=0xCAFEBABE next cycle, `busy` never rises; MTLO issued while busy → lo unchanged when the arithmetic op completes with its own result.
- MULTU 3×4 started, `cancel` in T+10 → `busy`=0 at T+11, hi/lo keep their prior values, no `done`; `start` with `cancel` together while idle → no state change.
- Reset asserted asynchronously at T+20 of a DIVU → `busy`, `done`, hi and lo all 0 immediately; after deassertion, MULTU 2×3 → lo=6, hi=0.
